muldiv_unit: RTL

Iterative RV32M/RV64M multiply/divide unit, parametrised on XLEN. It executes all eight M-extension operations selected by funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. It sits beside the single-cycle ALU in EX. The pipeline issues an operation through a valid/ready handshake and stalls until the result handshake completes. RISC-V divide-by-zero and signed-overflow results are produced by a one-cycle fast path.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_operand_prep.sv | 32 +++
 rtl/muldiv_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM states and funct3 decode helpers for muldiv_unit
package muldiv_pkg;
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    function automatic logic is_mul(input logic [2:0] f);
        return !f[2];
    endfunction

    function automatic logic a_signed(input logic [2:0] f);
        return f == OP_MULH || f == OP_MULHSU || f == OP_DIV || f == OP_REM;
    endfunction

    function automatic logic b_signed(input logic [2:0] f);
        return f == OP_MULH || f == OP_DIV || f == OP_REM;
    endfunction
endpackage

// File: rtl/muldiv_operand_prep.sv
// muldiv_operand_prep: operand magnitudes, sign flags and divide special-case detection
module muldiv_operand_prep
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] mag_a,
    output logic [XLEN-1:0] mag_b,
    output logic            neg_a,
    output logic            res_neg,
    output logic            special,
    output logic [XLEN-1:0] special_res
);
    logic neg_b, div_zero, ovf;

    always_comb begin
        neg_a       = a_signed(funct3) && op_a[XLEN-1];
        neg_b       = b_signed(funct3) && op_b[XLEN-1];
        mag_a       = neg_a ? -op_a : op_a;
        mag_b       = neg_b ? -op_b : op_b;
        res_neg     = neg_a ^ neg_b;
        div_zero    = !is_mul(funct3) && op_b == '0;
        ovf         = (funct3 == OP_DIV || funct3 == OP_REM) &&
                      op_a == {1'b1, {(XLEN-1){1'b0}}} && &op_b;
        special     = div_zero || ovf;
        // funct3[1] separates REM/REMU from DIV/DIVU
        special_res = funct3[1] ? (div_zero ? op_a : '0) : (div_zero ? '1 : op_a);
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit with valid/ready handshakes.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier on multiply ops.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    state_t            state, nxt;
    logic [CW-1:0]     cnt;
    logic [2:0]        fn;
    logic [2*XLEN-1:0] acc, acc_init, mul_nxt, prod;
    logic [XLEN:0]     rem, mul_sum, div_sh, div_diff;
    logic [XLEN-1:0]   opd, mag_a, mag_b, sp_res, quo, remv, fix_val;
    logic              neg_a, res_neg, special, quo_neg, rem_neg, fast, accept, take;

    muldiv_operand_prep #(.XLEN(XLEN)) u_prep (
        .funct3      (funct3),
        .op_a        (op_a),
        .op_b        (op_b),
        .mag_a       (mag_a),
        .mag_b       (mag_b),
        .neg_a       (neg_a),
        .res_neg     (res_neg),
        .special     (special),
        .special_res (sp_res)
    );

    assign in_ready  = state == IDLE && !kill;
    assign out_valid = state == DONE;
    assign accept    = in_valid && in_ready;

    always_comb begin
`ifdef MULDIV_FAST_MUL_EN
        fast     = is_mul(funct3);
        acc_init = fast ? (2*XLEN)'(mag_a) * (2*XLEN)'(mag_b) : {{XLEN{1'b0}}, mag_a};
`else
        fast     = 1'b0;
        acc_init = {{XLEN{1'b0}}, is_mul(funct3) ? mag_b : mag_a};
`endif
        // multiply: acc = {partial sum, remaining multiplier bits}
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : '0);
        mul_nxt  = {mul_sum, acc[XLEN-1:1]};
        // divide: dividend shifts out of acc low word as quotient bits shift in
        div_sh   = {rem[XLEN-1:0], acc[XLEN-1]};
        div_diff = div_sh - {1'b0, opd};
        take     = rem[XLEN] | ~div_diff[XLEN];
        prod     = quo_neg ? -acc : acc;
        quo      = quo_neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        remv     = rem_neg ? -rem[XLEN-1:0] : rem[XLEN-1:0];
        fix_val  = is_mul(fn) ? (fn == OP_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                              : (fn[1] ? remv : quo);
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = in_valid ? (special ? DONE : fast ? FIX : CALC) : IDLE;
            CALC:    nxt = cnt == CW'(XLEN-1) ? FIX : CALC;
            FIX:     nxt = DONE;
            default: nxt = out_ready ? IDLE : DONE;
        endcase
        if (kill)
            nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            result  <= '0;
            acc     <= '0;
            rem     <= '0;
            opd     <= '0;
            fn      <= '0;
            quo_neg <= 1'b0;
            rem_neg <= 1'b0;
        end else begin
            state <= nxt;
            if (accept) begin
                fn      <= funct3;
                cnt     <= '0;
                acc     <= acc_init;
                rem     <= '0;
                opd     <= is_mul(funct3) ? mag_a : mag_b;
                quo_neg <= res_neg;
                rem_neg <= neg_a;
                if (special)
                    result <= sp_res;
            end else if (state == CALC) begin
                cnt <= cnt + CW'(1);
                acc <= is_mul(fn) ? mul_nxt : {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], take};
                if (!is_mul(fn))
                    rem <= take ? div_diff : div_sh;
            end else if (state == FIX) begin
                result <= fix_val;
            end
        end
    end
endmodule
